// File: rtl/perf_counter_snapshot_ctrl.sv
// Performance counter bank with snapshot-and-stream control.
// A live bank counts event pulses; on a trigger (software, periodic timer or
// near-saturation) the live bank is copied into a shadow bank and streamed
// out over AXI-Stream, one counter per beat, while live counting restarts.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no snapshot in flight; a trigger captures and starts a stream
// ST_STREAM | shadow bank being streamed; triggers here are counted dropped
module perf_counter_snapshot_ctrl #(
    parameter int NUM_COUNTERS  = 115,
    parameter int COUNTER_WIDTH = 7,
    parameter int SEQ_WIDTH     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [31:0]             period,
    input  logic                    force_snapshot,
    input  logic [NUM_COUNTERS-1:0] performance_events,
    output logic [31:0]             m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic [15:0]             dropped_count
);

    localparam int IDX_W = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
    // Snapshot is taken one step before the ceiling so the value is never lost.
    localparam logic [COUNTER_WIDTH-1:0] CNT_HI  = CNT_MAX - COUNTER_WIDTH'(1);
    localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(NUM_COUNTERS - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [COUNTER_WIDTH-1:0] live_q   [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] shadow_q [NUM_COUNTERS];
    logic [31:0]              timer_q;
    logic [IDX_W-1:0]         idx_q;
    logic [SEQ_WIDTH-1:0]     seq_q;
    logic [15:0]              dropped_q;

    logic                     timer_hit;
    logic                     sat_any;
    logic                     sat_hit;
    logic                     trigger;
    logic                     capture;
    logic                     beat_fire;
    logic                     last_beat;
    logic                     stream_done;
    logic [COUNTER_WIDTH-1:0] shadow_rd;

    // Periodic trigger: fires whenever the timer has reached (or overshot,
    // after a period change) the last count of the interval.
    assign timer_hit = en && (period != 32'd0) && (timer_q >= (period - 32'd1));

    // Near-saturation detect across the live bank.
    always_comb begin
        sat_any = 1'b0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (live_q[i] >= CNT_HI) begin
                sat_any = 1'b1;
            end
        end
    end

    assign sat_hit     = en && sat_any;
    assign trigger     = force_snapshot || timer_hit || sat_hit;
    assign capture     = (state_q == ST_IDLE) && trigger;
    assign last_beat   = (idx_q == IDX_LAST);
    assign beat_fire   = m_axis_tvalid && m_axis_tready;
    assign stream_done = beat_fire && last_beat;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (stream_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        m_axis_tvalid = 1'b0;
        busy          = 1'b0;
        if (state_q == ST_STREAM) begin
            m_axis_tvalid = 1'b1;
            busy          = 1'b1;
        end
    end

    // Live bank: restart from this cycle's events on capture, else saturating count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                live_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                if (capture) begin
                    live_q[i] <= (en && performance_events[i]) ? COUNTER_WIDTH'(1) : '0;
                end else if (en && performance_events[i] && (live_q[i] != CNT_MAX)) begin
                    live_q[i] <= live_q[i] + COUNTER_WIDTH'(1);
                end
            end
        end
    end

    // Shadow bank: frozen copy of the live bank taken at capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                shadow_q[i] <= live_q[i];
            end
        end
    end

    // Interval timer: wraps on its own trigger, restarts on every capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= 32'd0;
        end else if (capture) begin
            timer_q <= 32'd0;
        end else if (en && (period != 32'd0)) begin
            if (timer_hit) begin
                timer_q <= 32'd0;
            end else begin
                timer_q <= timer_q + 32'd1;
            end
        end
    end

    // Beat index: starts at 0 on capture, advances on each accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (capture) begin
            idx_q <= '0;
        end else if (beat_fire) begin
            idx_q <= last_beat ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Sequence number: advances once per completed snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= '0;
        end else if (stream_done) begin
            seq_q <= seq_q + SEQ_WIDTH'(1);
        end
    end

    // Dropped counter: triggers seen while a stream is in flight, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped_q <= 16'd0;
        end else if ((state_q == ST_STREAM) && trigger && (dropped_q != 16'hFFFF)) begin
            dropped_q <= dropped_q + 16'd1;
        end
    end

    // Shadow read mux for the current beat.
    always_comb begin
        shadow_rd = '0;
        if (idx_q <= IDX_LAST) begin
            shadow_rd = shadow_q[idx_q];
        end
    end

    // Payload is forced to zero outside a stream so reset and idle read clean.
    assign m_axis_tdata  = m_axis_tvalid ? {8'(seq_q), 8'(idx_q), 16'(shadow_rd)} : 32'd0;
    assign m_axis_tlast  = m_axis_tvalid && last_beat;
    assign dropped_count = dropped_q;

endmodule

// File: tb/tb_perf_counter_snapshot_ctrl.sv
// Directed bench for perf_counter_snapshot_ctrl with four 7-bit counters.
module tb_perf_counter_snapshot_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] period;
    logic        force_snapshot;
    logic [3:0]  performance_events;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic [15:0] dropped_count;

    int n_tests = 0;
    int n_fail  = 0;

    perf_counter_snapshot_ctrl #(
        .NUM_COUNTERS (4),
        .COUNTER_WIDTH(7),
        .SEQ_WIDTH    (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .en                (en),
        .period            (period),
        .force_snapshot    (force_snapshot),
        .performance_events(performance_events),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast),
        .busy              (busy),
        .dropped_count     (dropped_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] td(input int s, input int i, input int v);
        return {s[7:0], i[7:0], v[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the beat presented this cycle (tready assumed high), then clocks it.
    task automatic beat(input string tag, input int s, input int i, input int v, input logic last);
        check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd1);
        check({tag, "_tdata"}, m_axis_tdata, td(s, i, v));
        check({tag, "_tlast"}, 32'(m_axis_tlast), 32'(last));
        step();
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        en                 = 1'b0;
        period             = 32'd0;
        force_snapshot     = 1'b0;
        performance_events = 4'b0000;
        m_axis_tready      = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n              = 1'b0;
        en                 = 1'b0;
        period             = 32'd0;
        force_snapshot     = 1'b0;
        performance_events = 4'b0000;
        m_axis_tready      = 1'b0;
        #3;
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("rst_dropped", 32'(dropped_count), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Periodic snapshot. Counters get one edge before the timer is armed,
        // then 9 timer edges bring them to 10; the 10th timer edge captures.
        m_axis_tready      = 1'b1;
        en                 = 1'b1;
        performance_events = 4'b0011;
        step();
        period = 32'd10;
        repeat (9) step();
        check("per_pre_tvalid", 32'(m_axis_tvalid), 32'd0);
        step();
        en = 1'b0;
        beat("per_b0", 0, 0, 10, 1'b0);
        beat("per_b1", 0, 1, 10, 1'b0);
        beat("per_b2", 0, 2, 0, 1'b0);
        beat("per_b3", 0, 3, 0, 1'b1);
        check("per_idle_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("per_idle_busy", 32'(busy), 32'd0);
        check("per_dropped", 32'(dropped_count), 32'd0);

        // Force and timer coincide: one snapshot, seq 1. Live holds {1,1,0,0}.
        performance_events = 4'b0000;
        en                 = 1'b1;
        period             = 32'd3;
        step();
        step();
        force_snapshot = 1'b1;
        step();
        force_snapshot = 1'b0;
        en             = 1'b0;
        beat("coin_b0", 1, 0, 1, 1'b0);
        beat("coin_b1", 1, 1, 1, 1'b0);
        beat("coin_b2", 1, 2, 0, 1'b0);
        beat("coin_b3", 1, 3, 0, 1'b1);
        check("coin_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("coin_dropped", 32'(dropped_count), 32'd0);
        force_snapshot = 1'b1;
        step();
        force_snapshot = 1'b0;
        beat("seq2_b0", 2, 0, 0, 1'b0);
        beat("seq2_b1", 2, 1, 0, 1'b0);
        beat("seq2_b2", 2, 2, 0, 1'b0);
        beat("seq2_b3", 2, 3, 0, 1'b1);

        // Period shrunk below the running timer value triggers at once.
        en     = 1'b1;
        period = 32'd100;
        repeat (20) step();
        check("pchg_pre_tvalid", 32'(m_axis_tvalid), 32'd0);
        period = 32'd5;
        step();
        check("pchg_tvalid", 32'(m_axis_tvalid), 32'd1);
        en = 1'b0;
        beat("pchg_b0", 3, 0, 0, 1'b0);
        beat("pchg_b1", 3, 1, 0, 1'b0);
        beat("pchg_b2", 3, 2, 0, 1'b0);
        beat("pchg_b3", 3, 3, 0, 1'b1);

        // Backpressure with drops; live bank becomes {3,5,3,3}.
        do_reset();
        en                 = 1'b1;
        performance_events = 4'b1111;
        repeat (3) step();
        performance_events = 4'b0010;
        repeat (2) step();
        en                 = 1'b0;
        performance_events = 4'b0000;
        force_snapshot     = 1'b1;
        step();
        force_snapshot = 1'b0;
        m_axis_tready  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            check("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("stall_tdata", m_axis_tdata, td(0, 0, 3));
            force_snapshot = (k == 5) || (k == 12);
            step();
        end
        force_snapshot = 1'b0;
        check("stall_dropped", 32'(dropped_count), 32'd2);
        m_axis_tready = 1'b1;
        beat("stall_b0", 0, 0, 3, 1'b0);
        beat("stall_b1", 0, 1, 5, 1'b0);
        beat("stall_b2", 0, 2, 3, 1'b0);
        force_snapshot = 1'b1;
        beat("stall_b3", 0, 3, 3, 1'b1);
        force_snapshot = 1'b0;
        check("lastfire_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("lastfire_dropped", 32'(dropped_count), 32'd3);

        // Asynchronous reset during beat 2 (seq is 1 here).
        force_snapshot = 1'b1;
        step();
        force_snapshot = 1'b0;
        beat("arst_b0", 1, 0, 0, 1'b0);
        beat("arst_b1", 1, 1, 0, 1'b0);
        check("arst_b2_tdata", m_axis_tdata, td(1, 2, 0));
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_tdata", m_axis_tdata, 32'd0);
        check("arst_dropped", 32'(dropped_count), 32'd0);
        step();
        rst_n              = 1'b1;
        en                 = 1'b1;
        performance_events = 4'b0001;
        repeat (3) step();
        en                 = 1'b0;
        performance_events = 4'b0000;
        force_snapshot     = 1'b1;
        step();
        force_snapshot = 1'b0;
        beat("post_b0", 0, 0, 3, 1'b0);
        beat("post_b1", 0, 1, 0, 1'b0);
        beat("post_b2", 0, 2, 0, 1'b0);
        beat("post_b3", 0, 3, 0, 1'b1);

        // Disabled counting ignores events; force still honoured.
        do_reset();
        performance_events = 4'b1111;
        repeat (50) step();
        force_snapshot = 1'b1;
        step();
        force_snapshot = 1'b0;
        beat("dis_b0", 0, 0, 0, 1'b0);
        beat("dis_b1", 0, 1, 0, 1'b0);
        beat("dis_b2", 0, 2, 0, 1'b0);
        beat("dis_b3", 0, 3, 0, 1'b1);

        // Saturation trigger at 126; counter caps at 127 while stream stalls.
        do_reset();
        en                 = 1'b1;
        performance_events = 4'b0001;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            n++;
            if (m_axis_tvalid) break;
        end
        check("sat_latency", 32'(n), 32'd127);
        m_axis_tready = 1'b0;
        check("sat_first_tdata", m_axis_tdata, td(0, 0, 126));
        repeat (200) step();
        check("sat_dropped", 32'(dropped_count), 32'd75);
        en            = 1'b0;
        m_axis_tready = 1'b1;
        beat("sat_b0", 0, 0, 126, 1'b0);
        beat("sat_b1", 0, 1, 0, 1'b0);
        beat("sat_b2", 0, 2, 0, 1'b0);
        beat("sat_b3", 0, 3, 0, 1'b1);
        force_snapshot = 1'b1;
        step();
        force_snapshot = 1'b0;
        beat("cap_b0", 1, 0, 127, 1'b0);
        beat("cap_b1", 1, 1, 0, 1'b0);
        beat("cap_b2", 1, 2, 0, 1'b0);
        beat("cap_b3", 1, 3, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
